// File: rtl/ws2812_stream.sv
// rtl/ws2812_stream.sv - WS2812/SK6812 LED chain driver with pixel prefetch
// Serialises pixels fetched over a req/valid handshake onto the single-wire DO line.
module ws2812_stream #(
  parameter int NUM_LEDS     = 64,
  parameter int BITS_PER_LED = 24,
  parameter int CLK_HZ       = 12_000_000,
  parameter int T0H_NS       = 350,
  parameter int T1H_NS       = 700,
  parameter int TBIT_NS      = 1250,
  parameter int TRESET_NS    = 80000,
  parameter int CONTINUOUS   = 0,
  localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    pixel_req,
  output logic [ADDR_W-1:0]       pixel_addr,
  input  logic [BITS_PER_LED-1:0] pixel_data,
  input  logic                    pixel_valid,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun,
  output logic                    DO
);

  localparam longint CLK_100K   = CLK_HZ / 100000;
  localparam int     T0H_CYC    = int'((CLK_100K * T0H_NS + 5000) / 10000);
  localparam int     T1H_CYC    = int'((CLK_100K * T1H_NS + 5000) / 10000);
  localparam int     TBIT_CYC   = int'((CLK_100K * TBIT_NS + 5000) / 10000);
  localparam int     TRESET_CYC = int'((CLK_100K * TRESET_NS + 5000) / 10000);
  localparam int     CNT_MAX    = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
  localparam int     CNT_W      = $clog2(CNT_MAX + 1);
  localparam int     BIT_W      = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
    $error("ws2812_stream: bit timing must satisfy 1 <= T0H < T1H < TBIT cycles");
  end

  typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic [ADDR_W-1:0]       led;
  logic [BITS_PER_LED-1:0] shreg, pf_data;
  logic                    pf_full;
  logic                    req_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    do_q;
  logic                    underrun_q;

  logic [CNT_W-1:0] hi_end;
  logic bit_done, last_bit, last_led, latch_end;
  logic shift_bit, load_next, underrun_evt, prefetch_issue;

  assign hi_end   = shreg[BITS_PER_LED-1] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign bit_done = (state == LOW) && (cnt == CNT_W'(TBIT_CYC - 1));
  assign last_bit = (bit_idx == BIT_W'(BITS_PER_LED - 1));
  assign last_led = (led == ADDR_W'(NUM_LEDS - 1));
  assign latch_end = (state == LATCH) && (cnt == CNT_W'(TRESET_CYC - 1));

  assign shift_bit    = bit_done && !last_bit;
  assign load_next    = bit_done && last_bit && !last_led && pf_full;
  assign underrun_evt = bit_done && last_bit && !last_led && !pf_full;
  // Issued one cycle into the first bit so the address never changes under an active request.
  assign prefetch_issue = (state == HIGH) && (cnt == '0) && (bit_idx == '0) && !last_led;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start || CONTINUOUS != 0) state_next = FETCH;
      FETCH: if (req_q && pixel_valid) state_next = HIGH;
      HIGH:  if (cnt == hi_end) state_next = LOW;
      LOW: begin
        if (bit_done) begin
          if (shift_bit || load_next) state_next = HIGH;
          else                        state_next = LATCH;
        end
      end
      LATCH: if (latch_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      led        <= '0;
      shreg      <= '0;
      pf_data    <= '0;
      pf_full    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      do_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state <= state_next;
      do_q  <= (state_next == HIGH);

      // One counter times both the bit period (HIGH then LOW) and the latch.
      if (state_next == LOW || (state_next == state && (state == HIGH || state == LATCH)))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;

      if (state == IDLE && state_next == FETCH) begin
        req_q   <= 1'b1;
        addr_q  <= '0;
        led     <= '0;
        pf_full <= 1'b0;
      end

      if (prefetch_issue) begin
        req_q  <= 1'b1;
        addr_q <= led + ADDR_W'(1);
      end

      if (req_q && pixel_valid) begin
        if (state == FETCH) begin
          shreg   <= pixel_data;
          bit_idx <= '0;
        end else begin
          pf_data <= pixel_data;
          pf_full <= 1'b1;
        end
        req_q <= 1'b0;
      end

      if (shift_bit) begin
        shreg   <= {shreg[BITS_PER_LED-2:0], 1'b0};
        bit_idx <= bit_idx + BIT_W'(1);
      end

      if (load_next) begin
        shreg   <= pf_data;
        pf_full <= 1'b0;
        bit_idx <= '0;
        led     <= led + ADDR_W'(1);
      end

      if (underrun_evt) begin
        underrun_q <= 1'b1;
        req_q      <= 1'b0;
      end

      if (latch_end) addr_q <= '0;
    end
  end

  assign pixel_req  = req_q;
  assign pixel_addr = addr_q;
  assign busy       = (state != IDLE);
  assign frame_done = latch_end;
  assign underrun   = underrun_q;
  assign DO         = do_q;

endmodule

// File: tb/tb_ws2812_stream.sv
// tb/tb_ws2812_stream.sv - scoreboard bench for ws2812_stream
// DO is decoded back into pixel words and compared against words queued at frame start.
`timescale 1ns/1ps
module tb_ws2812_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dut_a: two 24-bit LEDs, upstream with programmable latency / withholding
  logic        a_reset = 1'b1, a_start = 1'b0, a_valid = 1'b0;
  logic        a_req, a_busy, a_done, a_under, a_do;
  logic [0:0]  a_addr;
  logic [23:0] a_data;
  logic [23:0] mem_a [2];
  int          a_lag = 0;
  logic        a_block = 1'b0;
  int          a_age = 0;

  assign a_data = mem_a[a_addr];

  always @(negedge clk) begin
    a_age   = a_req ? a_age + 1 : 0;
    a_valid = a_req && (a_age > a_lag) && !(a_block && a_addr == 1'b1);
  end

  ws2812_stream #(.NUM_LEDS(2), .BITS_PER_LED(24)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .pixel_req(a_req), .pixel_addr(a_addr),
    .pixel_data(a_data), .pixel_valid(a_valid), .busy(a_busy), .frame_done(a_done),
    .underrun(a_under), .DO(a_do)
  );

  // dut_b: one 32-bit RGBW LED, data always valid
  logic        b_reset = 1'b1, b_start = 1'b0, b_valid = 1'b1;
  logic        b_req, b_busy, b_done, b_under, b_do;
  logic [0:0]  b_addr;
  logic [31:0] b_data = 32'h0000_00FF;

  ws2812_stream #(.NUM_LEDS(1), .BITS_PER_LED(32)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .pixel_req(b_req), .pixel_addr(b_addr),
    .pixel_data(b_data), .pixel_valid(b_valid), .busy(b_busy), .frame_done(b_done),
    .underrun(b_under), .DO(b_do)
  );

  // dut_c: continuous single-LED chain
  logic        c_reset = 1'b1, c_start = 1'b0, c_valid = 1'b1;
  logic        c_req, c_busy, c_done, c_under, c_do;
  logic [0:0]  c_addr;
  logic [23:0] c_data = 24'hA5A5A5;

  ws2812_stream #(.NUM_LEDS(1), .CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(c_reset), .start(c_start), .pixel_req(c_req), .pixel_addr(c_addr),
    .pixel_data(c_data), .pixel_valid(c_valid), .busy(c_busy), .frame_done(c_done),
    .underrun(c_under), .DO(c_do)
  );

  // Line monitors: channel 0 watches dut_a, channel 1 watches dut_b.
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic        m_prev  [2] = '{1'b0, 1'b0};
  int          m_hi    [2] = '{0, 0};
  int          m_since [2] = '{0, 0};
  int          m_nb    [2] = '{0, 0};
  int          m_pb    [2] = '{0, 0};
  int          m_exp   [2] = '{0, 0};
  logic [31:0] m_word  [2] = '{32'h0, 32'h0};

  task automatic mon_step(input int ch, input logic d, input logic done, input logic rst,
                          input int nbits);
    logic [31:0] e;
    if (rst) begin
      m_prev[ch] = 1'b0; m_hi[ch] = 0; m_since[ch] = 0;
      m_nb[ch] = 0; m_pb[ch] = 0; m_word[ch] = '0;
      return;
    end
    if (d && !m_prev[ch]) begin
      if (m_nb[ch] > 0) check($sformatf("ch%0d_bit_period", ch), m_since[ch], 15);
      m_since[ch] = 0;
      m_hi[ch]    = 0;
    end
    if (d) m_hi[ch]++;
    if (!d && m_prev[ch]) begin
      check($sformatf("ch%0d_high_len_is_4_or_8", ch), (m_hi[ch] == 4 || m_hi[ch] == 8), 1);
      m_word[ch] = {m_word[ch][30:0], (m_hi[ch] == 8)};
      m_nb[ch]++;
      m_pb[ch]++;
      if (m_pb[ch] == nbits) begin
        if ((ch == 0 && q_a.size() == 0) || (ch == 1 && q_b.size() == 0)) begin
          check($sformatf("ch%0d_unexpected_pixel", ch), 1, 0);
        end else begin
          e = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
          check($sformatf("ch%0d_pixel", ch), m_word[ch], e);
        end
        m_pb[ch]   = 0;
        m_word[ch] = '0;
      end
    end
    m_since[ch]++;
    if (done) begin
      check($sformatf("ch%0d_frame_bits", ch), m_nb[ch], m_exp[ch]);
      m_nb[ch] = 0; m_pb[ch] = 0; m_word[ch] = '0;
    end
    m_prev[ch] = d;
  endtask

  always @(negedge clk) mon_step(0, a_do, a_done, a_reset, 24);
  always @(negedge clk) mon_step(1, b_do, b_done, b_reset, 32);

  // One frame on dut_a with latency, prefetch, length and handshake checks.
  task automatic run_frame_a(input logic [23:0] p0, input logic [23:0] p1, input int lag,
                             input logic blk, input logic exp_under);
    int s, fr, r, pf, d, nb, busy_lo, addr_chg;
    logic prev_req;
    logic [0:0] prev_addr;
    fr = -1; r = -1; pf = -1; d = -1; busy_lo = 0; addr_chg = 0;
    prev_req = 1'b0; prev_addr = 1'b0;
    mem_a[0] = p0; mem_a[1] = p1; a_lag = lag; a_block = blk;
    nb = blk ? 24 : 48;
    m_exp[0] = nb;
    q_a.push_back({8'h0, p0});
    if (!blk) q_a.push_back({8'h0, p1});
    @(negedge clk);
    a_start = 1'b1;
    s = cyc + 1;
    for (int i = 0; i < 4000 && d < 0; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_req && fr < 0) begin
        fr = cyc;
        check("first_req_addr", a_addr, 0);
      end
      if (a_do && r < 0) r = cyc;
      if (a_req && a_addr == 1'b1 && pf < 0) pf = cyc;
      if (a_req && prev_req && a_addr != prev_addr) addr_chg++;
      if (!a_busy) busy_lo++;
      if (a_done) begin
        d = cyc;
        check("underrun_at_done", a_under, exp_under);
      end
      prev_req  = a_req;
      prev_addr = a_addr;
    end
    check("frame_done_seen", (d >= 0), 1);
    check("req_latency", fr - s, 0);
    check("do_rise_latency", r - s, 1 + lag);
    check("prefetch_addr1_cycle", pf - r, 1);
    check("frame_length", d - r, nb * 15 + 959);
    check("busy_during_frame", busy_lo, 0);
    check("addr_stable_under_req", addr_chg, 0);
    @(negedge clk);
    check("done_one_cycle", a_done, 0);
    check("busy_falls_after_done", a_busy, 0);
    check("idle_req_low", a_req, 0);
    check("idle_addr_zero", a_addr, 0);
  endtask

  typedef struct {
    logic [23:0] p0;
    logic [23:0] p1;
    int          lag;
    logic        blk;
    logic        exp_under;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s, r, d1, d2, req_after, got;
    vecs[0] = '{24'h800000, 24'h000001, 0,  1'b0, 1'b0};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 3,  1'b0, 1'b0};
    vecs[2] = '{24'h5A3C96, 24'hC3E10F, 17, 1'b0, 1'b0};
    vecs[3] = '{24'h123456, 24'h654321, 0,  1'b1, 1'b1};
    vecs[4] = '{24'hABCDEF, 24'h0F0F0F, 1,  1'b0, 1'b1};
    mem_a[0] = '0; mem_a[1] = '0;

    repeat (3) @(negedge clk);
    check("rst_do", a_do, 0);
    check("rst_busy", a_busy, 0);
    check("rst_req", a_req, 0);
    check("rst_addr", a_addr, 0);
    check("rst_done", a_done, 0);
    check("rst_underrun", a_under, 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", a_busy, 0);
    check("idle_req", a_req, 0);

    foreach (vecs[i]) run_frame_a(vecs[i].p0, vecs[i].p1, vecs[i].lag, vecs[i].blk, vecs[i].exp_under);

    // Reset while DO is high mid-bit.
    mem_a[0] = 24'hFFFFFF; mem_a[1] = 24'hFFFFFF; a_lag = 0; a_block = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (a_do) got = 1;
    end
    check("midbit_do_rise_seen", got, 1);
    repeat (3) @(negedge clk);
    check("midbit_do_high_before_reset", a_do, 1);
    a_reset = 1'b1;
    @(negedge clk);
    check("midreset_do", a_do, 0);
    check("midreset_busy", a_busy, 0);
    check("midreset_req", a_req, 0);
    check("midreset_done", a_done, 0);
    check("midreset_underrun_cleared", a_under, 0);
    @(negedge clk);
    a_reset = 1'b0;
    q_a.delete();
    run_frame_a(24'h00FF00, 24'h81C3E7, 2, 1'b0, 1'b0);

    // 32-bit LED, single LED chain: no prefetch ever.
    m_exp[1] = 32;
    q_b.push_back(32'h0000_00FF);
    @(negedge clk);
    b_start = 1'b1;
    s = cyc + 1;
    r = -1; d1 = -1; req_after = 0;
    for (int i = 0; i < 3000 && d1 < 0; i++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_do && r < 0) r = cyc;
      if (r >= 0 && b_req) req_after++;
      if (b_done) d1 = cyc;
    end
    check("b_do_rise_latency", r - s, 1);
    check("b_frame_length", d1 - r, 32 * 15 + 959);
    check("b_no_prefetch", req_after, 0);
    check("b_no_underrun", b_under, 0);
    @(negedge clk);
    check("b_busy_falls", b_busy, 0);

    // Continuous mode; start held high must not disturb the cadence.
    c_start = 1'b1;
    @(negedge clk);
    c_reset = 1'b0;
    d1 = -1;
    for (int i = 0; i < 3000 && d1 < 0; i++) begin
      @(negedge clk);
      if (c_done) d1 = cyc;
    end
    check("c_first_done_seen", (d1 >= 0), 1);
    @(negedge clk);
    check("c_idle_busy", c_busy, 0);
    check("c_idle_req", c_req, 0);
    @(negedge clk);
    check("c_restart_req", c_req, 1);
    check("c_restart_addr", c_addr, 0);
    d2 = -1;
    for (int i = 0; i < 3000 && d2 < 0; i++) begin
      @(negedge clk);
      if (c_done) d2 = cyc;
    end
    check("c_frame_period", d2 - d1, 1322);
    c_start = 1'b0;
    d1 = d2; d2 = -1;
    for (int i = 0; i < 3000 && d2 < 0; i++) begin
      @(negedge clk);
      if (c_done) d2 = cyc;
    end
    check("c_frame_period_no_start", d2 - d1, 1322);
    check("c_no_underrun", c_under, 0);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_stream.md
Name: ws2812_stream

Overview:
- Parametrised next-generation driver for WS2812/SK6812-class single-wire LED chains.
- Generalises the fixed 24-bit, fixed-timing driver:
  - configurable bits per LED (24 RGB / 32 RGBW),
  - nanosecond-specified bit timing,
  - one-shot or continuous frame mode.
- Fetches pixels from an upstream frame store via a req/valid handshake.
- Prefetches the next pixel during the current LED, so there is no inter-LED gap.
- Reports underruns.

Parameters:
- NUM_LEDS, 64, LEDs per frame (>=1); ADDR_W = max(1, ceil(log2(NUM_LEDS))).
- BITS_PER_LED, 24, bits shifted per LED (24 or 32), MSB first; colour order is the caller's packing.
- CLK_HZ, 12_000_000, clk frequency; must be a multiple of 100_000.
- T0H_NS, 350, high time for a '0' bit.
- T1H_NS, 700, high time for a '1' bit.
- TBIT_NS, 1250, total bit period.
- TRESET_NS, 80000, low latch time after a frame.
- CONTINUOUS, 0, 1 = restart a frame automatically after each latch.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled in IDLE only
- pixel_req  out  1  request for the pixel at pixel_addr
- pixel_addr  out  ADDR_W  LED index being requested
- pixel_data  in  BITS_PER_LED  pixel word; sampled when pixel_req && pixel_valid
- pixel_valid  in  1  upstream data-valid
- busy  out  1  high from frame start until latch end
- frame_done  out  1  one-cycle pulse at end of latch
- underrun  out  1  sticky; set when a pixel was not ready in time
- DO  out  1  serial line to the LED chain

Behaviour:
Cycle counts and elaboration:
- Cycle count X_CYC = ((CLK_HZ/100000)*X_NS + 5000)/10000, i.e. rounded.
- Default counts: T0H=4, T1H=8, TBIT=15, TRESET=960.
- Elaboration error unless 1 <= T0H_CYC < T1H_CYC < TBIT_CYC.

Reset:
- All outputs 0; pixel buffers empty; state IDLE.
- Reset mid-frame: DO=0 at the next edge; no frame_done pulse.
- underrun is cleared only by reset.

State machine:
- IDLE:
  - DO=0, busy=0.
  - If start=1 (or CONTINUOUS=1), go to FETCH with pixel_addr=0.
  - busy=1 and pixel_req=1 from the next cycle.
- FETCH (first pixel only):
  - Hold pixel_req=1 and pixel_addr until pixel_valid.
  - On the valid cycle, load the shift register and drop pixel_req.
  - Next cycle: state HIGH, DO=1.
- HIGH:
  - DO=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles; then go to LOW.
- LOW:
  - DO=0 for the remainder of the TBIT_CYC period; the bit period is exactly TBIT_CYC cycles.
  - Then, if bits remain, shift and go to HIGH.
- LED boundary:
  - After the last bit of LED k: if k == NUM_LEDS-1, go to LATCH.
  - Otherwise the prefetch buffer must be full: load it and go to HIGH with no gap.
  - If the buffer is empty: set underrun, drop pixel_req, go to LATCH. The frame is aborted and DO stays low.
- Prefetch:
  - When LED k's first bit enters HIGH and k < NUM_LEDS-1, assert pixel_req with pixel_addr=k+1.
  - Hold until pixel_valid, capture into the prefetch buffer, then drop pixel_req.
- LATCH:
  - DO=0 for TRESET_CYC cycles, counted from the first LATCH cycle.
  - On the last cycle: frame_done=1, busy=0 from the next cycle, return to IDLE.
  - In CONTINUOUS mode IDLE immediately re-enters FETCH, so IDLE lasts exactly 1 cycle.

Handshake and edge cases:
- pixel_valid is ignored while pixel_req=0.
- start is ignored while busy.
- start and frame_done in the same cycle: start is ignored.
- pixel_addr stays stable while pixel_req=1.
- pixel_addr is 0 whenever pixel_req=0 in IDLE.
- NUM_LEDS=1: no prefetch ever issued.
- Counters are sized from TRESET_CYC and TBIT_CYC; no wrap within a frame.

Test Plan:
1. Defaults, NUM_LEDS=2, pixel_valid tied 1, start pulse:
   - pixel_req at start+1 (addr 0); DO rises start+2.
   - Pixel 0x800000: first bit high 8 cycles, then 15-cycle period; the remaining 23 bits high 4 cycles each.
2. Back-to-back LEDs:
   - The LED0→LED1 boundary shows the DO rising edge exactly 15 cycles after the previous bit's rise.
   - pixel_addr=1 requested during LED0's first bit.
   - After LED1: DO low 960 cycles, one frame_done pulse, busy falls the next cycle.
3. BITS_PER_LED=32, pixel 0x0000_00FF:
   - 24 short (4-cycle) pulses, then 8 long (8-cycle) pulses.
   - Frame length = 32×15 + 960 cycles after the first DO rise.
4. Underrun:
   - pixel_valid for addr 1 withheld past the end of LED0's 24th bit.
   - underrun=1, DO stays 0, LATCH 960 cycles, frame_done pulses.
   - underrun stays 1 after the next start.
5. CONTINUOUS=1, NUM_LEDS=1:
   - Frames repeat with exactly one IDLE cycle between frame_done and the next pixel_req.
   - start has no effect.
6. Reset asserted mid-bit while DO=1:
   - DO=0, busy=0, pixel_req=0 on the next edge.
   - A new start runs a clean frame from addr 0.
